// File: rtl/biu_bus_arbiter.sv
// Arbitrates the EU data path and the prefetch queue onto the single memory_controller port.
// One transaction at a time; EU has priority, PF is forced after EU_BURST consecutive EU grants.
module biu_bus_arbiter #(
  parameter int unsigned WIDTH_DATA   = 16,
  parameter int unsigned WIDTH_ADDR   = 20,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned EU_BURST     = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  eu_req,
  input  logic                  eu_we,
  input  logic [WIDTH_ADDR-1:0] eu_addr,
  input  logic [WIDTH_DATA-1:0] eu_wdata,
  output logic [WIDTH_DATA-1:0] eu_rdata,
  output logic                  eu_ack,
  input  logic                  pf_req,
  input  logic [WIDTH_ADDR-1:0] pf_addr,
  input  logic                  pf_flush,
  output logic [WIDTH_DATA-1:0] pf_rdata,
  output logic                  pf_ack,
  output logic                  mem_read_enable,
  output logic [WIDTH_ADDR-1:0] mem_read_address,
  input  logic [WIDTH_DATA-1:0] mem_read_data,
  output logic                  mem_write_enable,
  output logic [WIDTH_ADDR-1:0] mem_write_address,
  output logic [WIDTH_DATA-1:0] mem_write_data,
  output logic                  busy,
  output logic                  owner
);

  typedef enum logic [1:0] {StIdle, StAccess, StWait, StResp} state_e;

  localparam logic [2:0] LatInit  = 3'(READ_LATENCY);
  localparam logic [3:0] BurstMax = 4'(EU_BURST);

  state_e                state_q, state_d;
  logic [WIDTH_ADDR-1:0] addr_q, addr_d;
  logic [WIDTH_DATA-1:0] wdata_q, wdata_d;
  logic [WIDTH_DATA-1:0] eu_rdata_q, eu_rdata_d;
  logic [WIDTH_DATA-1:0] pf_rdata_q, pf_rdata_d;
  logic                  we_q, we_d;
  logic                  owner_q, owner_d;
  logic                  flush_q, flush_d;
  logic [2:0]            lat_q, lat_d;
  logic [3:0]            burst_q, burst_d;
  logic                  pf_turn;
  logic                  capture;

  assign pf_turn = pf_req && (burst_q == BurstMax);

  always_comb begin
    state_d           = state_q;
    addr_d            = addr_q;
    wdata_d           = wdata_q;
    we_d              = we_q;
    owner_d           = owner_q;
    flush_d           = flush_q;
    lat_d             = lat_q;
    burst_d           = burst_q;
    eu_rdata_d        = eu_rdata_q;
    pf_rdata_d        = pf_rdata_q;
    capture           = 1'b0;
    eu_ack            = 1'b0;
    pf_ack            = 1'b0;
    mem_read_enable   = 1'b0;
    mem_read_address  = '0;
    mem_write_enable  = 1'b0;
    mem_write_address = '0;
    mem_write_data    = '0;

    unique case (state_q)
      StIdle: begin
        flush_d = 1'b0;
        if (eu_req && !pf_turn) begin
          addr_d  = eu_addr;
          we_d    = eu_we;
          wdata_d = eu_wdata;
          owner_d = 1'b0;
          state_d = StAccess;
          if (!pf_req) begin
            burst_d = '0;
          end else if (burst_q != BurstMax) begin
            burst_d = burst_q + 4'd1;
          end
        end else if (pf_req) begin
          addr_d  = pf_addr;
          we_d    = 1'b0;
          wdata_d = '0;
          owner_d = 1'b1;
          burst_d = '0;
          state_d = StAccess;
        end
      end
      StAccess: begin
        if (we_q) begin
          mem_write_enable  = 1'b1;
          mem_write_address = addr_q;
          mem_write_data    = wdata_q;
          state_d           = StResp;
        end else begin
          mem_read_enable  = 1'b1;
          mem_read_address = addr_q;
          if (LatInit == 3'd0) begin
            capture = 1'b1;
            state_d = StResp;
          end else begin
            lat_d   = LatInit;
            state_d = StWait;
          end
        end
      end
      StWait: begin
        mem_read_enable  = 1'b1;
        mem_read_address = addr_q;
        if (lat_q <= 3'd1) begin
          capture = 1'b1;
          lat_d   = '0;
          state_d = StResp;
        end else begin
          lat_d = lat_q - 3'd1;
        end
      end
      StResp: begin
        eu_ack  = !owner_q;
        // A flush landing in the response cycle itself must also swallow the ack.
        pf_ack  = owner_q && !flush_q && !pf_flush;
        flush_d = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (pf_flush && owner_q && (state_q == StAccess || state_q == StWait)) begin
      flush_d = 1'b1;
    end

    if (capture) begin
      if (owner_q) begin
        pf_rdata_d = mem_read_data;
      end else begin
        eu_rdata_d = mem_read_data;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      owner_q    <= 1'b0;
      flush_q    <= 1'b0;
      lat_q      <= '0;
      burst_q    <= '0;
      eu_rdata_q <= '0;
      pf_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      owner_q    <= owner_d;
      flush_q    <= flush_d;
      lat_q      <= lat_d;
      burst_q    <= burst_d;
      eu_rdata_q <= eu_rdata_d;
      pf_rdata_q <= pf_rdata_d;
    end
  end

  assign eu_rdata = eu_rdata_q;
  assign pf_rdata = pf_rdata_q;
  assign busy     = (state_q != StIdle);
  assign owner    = owner_q;

endmodule

// File: tb/tb_biu_bus_arbiter.sv
// Bench for biu_bus_arbiter: instance 0 has READ_LATENCY=1, instance 1 has READ_LATENCY=0.
// Each has a latency-accurate memory model; expectations come from a transaction-level model.
module tb_biu_bus_arbiter;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  logic        eu_req [2];
  logic        eu_we [2];
  logic [19:0] eu_addr [2];
  logic [15:0] eu_wdata [2];
  logic [15:0] eu_rdata [2];
  logic        eu_ack [2];
  logic        pf_req [2];
  logic [19:0] pf_addr [2];
  logic        pf_flush [2];
  logic [15:0] pf_rdata [2];
  logic        pf_ack [2];
  logic        mem_re [2];
  logic [19:0] mem_ra [2];
  logic [15:0] mem_rd [2];
  logic        mem_we [2];
  logic [19:0] mem_wa [2];
  logic [15:0] mem_wd [2];
  logic        busy [2];
  logic        owner [2];

  // Reference memory image, one per instance.
  bit   [15:0] ref_mem [2][16];
  bit          ref_wr [2][16];

  function automatic logic [15:0] init_word(input logic [3:0] a);
    return {4'hA, a, 4'h5, ~a};
  endfunction

  function automatic logic [15:0] ref_read(input int d, input logic [19:0] a);
    return ref_wr[d][a[3:0]] ? ref_mem[d][a[3:0]] : init_word(a[3:0]);
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int Lat = (g == 0) ? 1 : 0;
    bit [15:0]   mem [16];
    bit [15:0]   written;
    int          rd_run;
    logic [15:0] rd_word;

    biu_bus_arbiter #(
      .WIDTH_DATA  (16),
      .WIDTH_ADDR  (20),
      .READ_LATENCY(Lat),
      .EU_BURST    (4)
    ) dut (
      .clock            (clock),
      .reset            (reset),
      .eu_req           (eu_req[g]),
      .eu_we            (eu_we[g]),
      .eu_addr          (eu_addr[g]),
      .eu_wdata         (eu_wdata[g]),
      .eu_rdata         (eu_rdata[g]),
      .eu_ack           (eu_ack[g]),
      .pf_req           (pf_req[g]),
      .pf_addr          (pf_addr[g]),
      .pf_flush         (pf_flush[g]),
      .pf_rdata         (pf_rdata[g]),
      .pf_ack           (pf_ack[g]),
      .mem_read_enable  (mem_re[g]),
      .mem_read_address (mem_ra[g]),
      .mem_read_data    (mem_rd[g]),
      .mem_write_enable (mem_we[g]),
      .mem_write_address(mem_wa[g]),
      .mem_write_data   (mem_wd[g]),
      .busy             (busy[g]),
      .owner            (owner[g])
    );

    // Data is only valid Lat cycles into a run of read_enable; otherwise garbage.
    always @(posedge clock) begin
      if (mem_re[g] === 1'b1) rd_run <= rd_run + 1;
      else rd_run <= 0;
      if (mem_we[g] === 1'b1) begin
        mem[mem_wa[g][3:0]]     <= mem_wd[g];
        written[mem_wa[g][3:0]] <= 1'b1;
      end
    end

    always_comb begin
      rd_word = written[mem_ra[g][3:0]] ? mem[mem_ra[g][3:0]] : init_word(mem_ra[g][3:0]);
    end

    assign mem_rd[g] = (mem_re[g] === 1'b1 && rd_run == Lat) ? rd_word : ~rd_word;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Runs one transaction starting in an IDLE cycle; k counts cycles from the request cycle.
  task automatic txn(input int d, input bit pf, input bit we, input logic [19:0] a,
                     input logic [15:0] wd, input int flush_k, input string tag);
    int lat, acc, ack_at, idle_at, own_n, other_n, re_n, we_n, bad;
    bit flushed;
    logic [15:0] exp_rd;
    lat     = (d == 0) ? 1 : 0;
    acc     = we ? 1 : lat + 1;
    ack_at  = -1;
    idle_at = -1;
    own_n   = 0;
    other_n = 0;
    re_n    = 0;
    we_n    = 0;
    bad     = 0;
    flushed = pf && flush_k >= 1 && flush_k <= acc + 1;
    exp_rd  = ref_read(d, a);
    if (pf) begin
      pf_req[d]  = 1'b1;
      pf_addr[d] = a;
    end else begin
      eu_req[d]   = 1'b1;
      eu_we[d]    = we;
      eu_addr[d]  = a;
      eu_wdata[d] = wd;
    end
    for (int k = 0; k < 24 && idle_at < 0; k++) begin
      pf_flush[d] = (k == flush_k);
      #3;
      if ((pf ? pf_ack[d] : eu_ack[d]) === 1'b1) begin
        own_n++;
        if (ack_at < 0) ack_at = k;
      end
      if ((pf ? eu_ack[d] : pf_ack[d]) === 1'b1) other_n++;
      if (mem_re[d] === 1'b1) begin
        re_n++;
        if (mem_ra[d] !== a) bad++;
      end
      if (mem_we[d] === 1'b1) begin
        we_n++;
        if (mem_wa[d] !== a || mem_wd[d] !== wd) bad++;
      end
      if (k > 0 && busy[d] === 1'b0) idle_at = k;
      tick();
      pf_flush[d] = 1'b0;
      if (k == acc + 1) begin
        eu_req[d] = 1'b0;
        pf_req[d] = 1'b0;
      end
    end
    eu_req[d] = 1'b0;
    pf_req[d] = 1'b0;
    chk({tag, ":ack_cycle"}, ack_at, flushed ? -1 : acc + 1);
    chk({tag, ":ack_count"}, own_n, flushed ? 0 : 1);
    chk({tag, ":other_ack"}, other_n, 0);
    chk({tag, ":idle_cycle"}, idle_at, acc + 2);
    chk({tag, ":rd_en_cycles"}, re_n, we ? 0 : lat + 1);
    chk({tag, ":wr_en_cycles"}, we_n, we ? 1 : 0);
    chk({tag, ":mem_addr_data"}, bad, 0);
    chk({tag, ":owner"}, owner[d], pf);
    if (we) begin
      ref_mem[d][a[3:0]] = wd;
      ref_wr[d][a[3:0]]  = 1'b1;
    end else begin
      chk({tag, ":rdata"}, pf ? pf_rdata[d] : eu_rdata[d], exp_rd);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int b, g, eu_n, pf_n, exp_pf, prev_busy;
    bit exp_owner, done;
    bit rpf, rwe;
    int rflush;

    for (int d = 0; d < 2; d++) begin
      eu_req[d] = 0; eu_we[d] = 0; eu_addr[d] = '0; eu_wdata[d] = '0;
      pf_req[d] = 0; pf_addr[d] = '0; pf_flush[d] = 0;
    end
    reset = 1'b1;
    tick(); tick(); tick();
    reset = 1'b0;
    #3;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst%0d:busy", d), busy[d], 0);
      chk($sformatf("rst%0d:owner", d), owner[d], 0);
      chk($sformatf("rst%0d:acks", d), {eu_ack[d], pf_ack[d]}, 0);
      chk($sformatf("rst%0d:mem_en", d), {mem_re[d], mem_we[d]}, 0);
      chk($sformatf("rst%0d:rdata", d), {eu_rdata[d], pf_rdata[d]}, 0);
    end
    tick();

    // Directed: writes and reads on the latency-1 instance.
    txn(0, 0, 1, 20'h00004, 16'hBEEF, -1, "t1_wr");
    txn(0, 0, 0, 20'h00004, 16'h0000, -1, "t1_rd");
    txn(0, 0, 1, 20'h00002, 16'h1234, -1, "t2_wr");
    txn(0, 0, 0, 20'h00002, 16'h0000, -1, "t2_rd");

    // Flush during WAIT, then in RESP, then in IDLE (no effect), then a normal PF read.
    txn(0, 1, 0, 20'hF0003, 16'h0000, 2, "t4_flush_wait");
    txn(0, 1, 0, 20'hF0003, 16'h0000, 3, "t4_flush_resp");
    txn(0, 1, 0, 20'hF0005, 16'h0000, 0, "t4_flush_idle");
    txn(0, 1, 0, 20'hF0003, 16'h0000, -1, "t4_after");

    // Continuous contention: grant order from the burst rule.
    eu_req[0] = 1; eu_we[0] = 0; eu_addr[0] = 20'h00003;
    pf_req[0] = 1; pf_addr[0] = 20'h00007;
    b = 0; g = 0; eu_n = 0; pf_n = 0; exp_pf = 0; prev_busy = 0;
    for (int c = 0; c < 200 && g < 10; c++) begin
      #3;
      if (eu_ack[0] === 1'b1) eu_n++;
      if (pf_ack[0] === 1'b1) pf_n++;
      if (busy[0] === 1'b1 && prev_busy == 0) begin
        exp_owner = (b == 4);
        chk($sformatf("t3_grant%0d", g), owner[0], exp_owner);
        if (exp_owner) begin
          b = 0;
          exp_pf++;
        end else begin
          b = (b < 4) ? b + 1 : 4;
        end
        g++;
      end
      prev_busy = (busy[0] === 1'b1) ? 1 : 0;
      tick();
    end
    eu_req[0] = 0;
    pf_req[0] = 0;
    done = 0;
    for (int c = 0; c < 20 && !done; c++) begin
      #3;
      if (eu_ack[0] === 1'b1) eu_n++;
      if (pf_ack[0] === 1'b1) pf_n++;
      if (busy[0] === 1'b0) done = 1;
      tick();
    end
    chk("t3_grants", g, 10);
    chk("t3_drained", done, 1);
    chk("t3_pf_acks", pf_n, exp_pf);
    chk("t3_eu_acks", eu_n, 10 - exp_pf);

    // Reset during WAIT of an EU read.
    eu_req[0] = 1; eu_we[0] = 0; eu_addr[0] = 20'h00009;
    tick(); tick();
    #3;
    chk("t5_in_wait", mem_re[0], 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    eu_req[0] = 0;
    #3;
    chk("t5_busy", busy[0], 0);
    chk("t5_ack", {eu_ack[0], pf_ack[0]}, 0);
    chk("t5_mem_en", {mem_re[0], mem_we[0]}, 0);
    chk("t5_mem_addr", mem_ra[0], 0);
    chk("t5_owner", owner[0], 0);
    chk("t5_rdata", eu_rdata[0], 0);
    tick();
    txn(0, 0, 0, 20'h00009, 16'h0000, -1, "t5_after");

    // Zero-latency instance.
    txn(1, 1, 0, 20'hF0003, 16'h0000, -1, "t6_pf_rd");
    txn(1, 0, 1, 20'h0000A, 16'h5A5A, -1, "t6_eu_wr");
    txn(1, 0, 0, 20'h0000A, 16'h0000, -1, "t6_eu_rd");
    txn(1, 1, 0, 20'h1000A, 16'h0000, 1, "t6_pf_flush");

    // Randomized single-requester traffic.
    for (int i = 0; i < 30; i++) begin
      rpf    = ($urandom_range(0, 2) == 0);
      rwe    = rpf ? 1'b0 : 1'($urandom_range(0, 1));
      rflush = rpf ? int'($urandom_range(0, 5)) - 1 : -1;
      txn(0, rpf, rwe, 20'($urandom), 16'($urandom), rflush, $sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
